// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: EX/ID operand forwarding,
// load-use and branch stalls, and sequencing of the multicycle EX-stage divider.
module hazard_fwd_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_e,
  input  logic [4:0] writereg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  input  logic       memtoreg_e,
  input  logic       memtoreg_m,
  input  logic       branch_d,
  input  logic       div_e,
  input  logic       div_done,
  output logic [1:0] forwardae,
  output logic [1:0] forwardbe,
  output logic       forwardad,
  output logic       forwardbd,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       flush_e,
  output logic       div_start,
  output logic       div_busy,
  output logic       div_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t       state_r;
  div_state_t       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             div_err_r;
  logic             div_busy_r;
  logic [1:0]       fwd_ae_s;
  logic [1:0]       fwd_be_s;
  logic             fwd_ad_s;
  logic             fwd_bd_s;
  logic             lwstall_s;
  logic             branchstall_s;
  logic             divstall_s;
  logic             stall_s;
  logic             flush_s;
  logic             start_s;
  logic             set_err_s;
  logic             timeout_s;

  // Register 0 is hard-wired, so a match on it is never a real dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic en);
    return en & (src != 5'd0) & (dst == src);
  endfunction

  // EX-stage operand selects (MEM has priority over WB) and ID compare forwards
  always_comb begin
    fwd_ae_s = 2'b00;
    fwd_be_s = 2'b00;
    if (reg_match(rs_e, writereg_m, regwrite_m)) begin
      fwd_ae_s = 2'b10;
    end else if (reg_match(rs_e, writereg_w, regwrite_w)) begin
      fwd_ae_s = 2'b01;
    end else begin
      fwd_ae_s = 2'b00;
    end
    if (reg_match(rt_e, writereg_m, regwrite_m)) begin
      fwd_be_s = 2'b10;
    end else if (reg_match(rt_e, writereg_w, regwrite_w)) begin
      fwd_be_s = 2'b01;
    end else begin
      fwd_be_s = 2'b00;
    end
    fwd_ad_s = reg_match(rs_d, writereg_m, regwrite_m);
    fwd_bd_s = reg_match(rt_d, writereg_m, regwrite_m);
  end

  // Load-use and branch-in-ID hazard detection
  always_comb begin
    lwstall_s     = reg_match(rs_d, writereg_e, memtoreg_e) |
                    reg_match(rt_d, writereg_e, memtoreg_e);
    branchstall_s = branch_d & (reg_match(rs_d, writereg_e, regwrite_e) |
                                reg_match(rt_d, writereg_e, regwrite_e) |
                                reg_match(rs_d, writereg_m, memtoreg_m) |
                                reg_match(rt_d, writereg_m, memtoreg_m));
  end

  assign timeout_s = (cnt_r == CNT_W'(DIV_TIMEOUT - 1));

  // Divider sequencing: launch from IDLE, wait in BUSY, one-cycle DONE release
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (div_e) begin
          start_s      = 1'b1;
          next_state_s = BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (div_done) begin
          next_state_s = DONE;
        end else if (timeout_s) begin
          set_err_s    = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Pipeline holds; a held divide in EX must never be replaced by a bubble
  always_comb begin
    divstall_s = ((state_r == IDLE) & div_e) | (state_r == BUSY);
    stall_s    = lwstall_s | branchstall_s | divstall_s;
    flush_s    = (lwstall_s | branchstall_s) & ~divstall_s;
  end

  // Divider state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Watchdog counter, cleared on each launch and advanced while BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (start_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky timeout flag and registered busy indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_err_r  <= 1'b0;
      div_busy_r <= 1'b0;
    end else begin
      div_err_r  <= div_err_r | set_err_s;
      div_busy_r <= (next_state_s != IDLE);
    end
  end

  assign forwardae = fwd_ae_s;
  assign forwardbe = fwd_be_s;
  assign forwardad = fwd_ad_s;
  assign forwardbd = fwd_bd_s;
  assign stall_f   = stall_s;
  assign stall_d   = stall_s;
  assign stall_e   = divstall_s;
  assign flush_e   = flush_s;
  assign div_start = start_s;
  assign div_busy  = div_busy_r;
  assign div_err   = div_err_r;

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the 2-bit selects of the EX-stage 3:1 forwarding muxes and the 1-bit ID-stage branch-compare forwards.
- Generates stall/flush for load-use and branch-in-ID hazards.
- Sequences the multicycle divider in EX: start pulse, pipeline hold until done, watchdog timeout.

Parameters:
- DIV_TIMEOUT, 64: max cycles in BUSY before forced abort.
- CNT_W, 7: width of the watchdog counter; must satisfy 2^CNT_W > DIV_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs_d, rt_d  in  5  source register numbers in ID.
- rs_e, rt_e  in  5  source register numbers in EX.
- writereg_e, writereg_m, writereg_w  in  5  destination register numbers in EX/MEM/WB.
- regwrite_e, regwrite_m, regwrite_w  in  1  register-write enables in EX/MEM/WB.
- memtoreg_e, memtoreg_m  in  1  load-instruction flags in EX/MEM.
- branch_d  in  1  branch being resolved in ID.
- div_e  in  1  divide instruction occupies EX.
- div_done  in  1  divider result valid, single-cycle pulse.
- forwardae, forwardbe  out  2  EX operand selects: 00 = regfile, 01 = WB result, 10 = MEM ALU result.
- forwardad, forwardbd  out  1  ID compare operand takes MEM ALU result.
- stall_f, stall_d, stall_e  out  1  hold the PC, IF/ID and ID/EX registers.
- flush_e  out  1  clear the ID/EX register (inject bubble).
- div_start  out  1  divider launch pulse.
- div_busy  out  1  FSM not in IDLE.
- div_err  out  1  sticky watchdog-timeout flag.

Behaviour:
- Forwarding (combinational):
  - forwardae = 10 if rs_e != 0 & regwrite_m & writereg_m == rs_e.
  - Else 01 if rs_e != 0 & regwrite_w & writereg_w == rs_e.
  - Else 00. MEM beats WB. Value 11 is never driven. forwardbe is identical using rt_e.
  - forwardad = rs_d != 0 & regwrite_m & writereg_m == rs_d. forwardbd is the same with rt_d.
- lwstall = memtoreg_e & writereg_e != 0 & (writereg_e == rs_d | writereg_e == rt_d).
- branchstall = branch_d & ((regwrite_e & writereg_e != 0 & writereg_e ∈ {rs_d, rt_d}) | (memtoreg_m & writereg_m != 0 & writereg_m ∈ {rs_d, rt_d})).
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE: if div_e = 1, assert div_start combinationally this cycle and go to BUSY. div_done is ignored in IDLE.
  - BUSY: counter increments each cycle.
    - If div_done = 1, go to DONE.
    - Else if counter == DIV_TIMEOUT-1, set div_err = 1 and go to DONE.
    - If div_done and the timeout coincide, div_done wins and div_err is not set.
  - DONE: single cycle, no stall, so the divide leaves EX; next state is IDLE.
    - A back-to-back divide enters EX on this edge and is launched from IDLE on the following cycle.
  - Counter clears on entry to BUSY.
- divstall = (state == IDLE & div_e) | state == BUSY.
- Stall and flush outputs:
  - stall_f = stall_d = lwstall | branchstall | divstall.
  - stall_e = divstall.
  - flush_e = (lwstall | branchstall) & ~divstall. A bubble is never injected over a held divide.
- div_busy = state != IDLE, registered.
- Reset (asynchronous, any time including mid-divide):
  - state = IDLE, counter = 0, div_err = 0, div_busy = 0.
  - Combinational outputs then follow the inputs; div_start is 0 unless div_e = 1.
  - An in-flight divide is abandoned; the divider is reset by the same rst.
- div_err clears only on rst.

Test Plan:
- Forward priority: rs_e = 5, regwrite_m = 1, writereg_m = 5, regwrite_w = 1, writereg_w = 5 -> forwardae = 10; drop regwrite_m -> 01; rs_e = 0 with both matches -> 00.
- Load-use: memtoreg_e = 1, writereg_e = 8, rt_d = 8 -> stall_f = stall_d = flush_e = 1, stall_e = 0. With writereg_e = 0 -> all 0.
- Branch hazard: branch_d = 1, rs_d = 3, regwrite_e = 1, writereg_e = 3 -> stall + flush_e for 1 cycle. Next cycle with writereg_m = 3, memtoreg_m = 0 -> no stall, forwardad = 1.
- Divide: div_e = 1 at cycle 0 -> div_start = 1 at cycle 0 only. div_busy = 1 from cycle 1; stall_e = 1 cycles 0..5 with div_done at cycle 5. DONE at cycle 6 with stall_e = 0; div_busy = 0 at cycle 7.
- Timeout: DIV_TIMEOUT = 4, div_done never -> BUSY 4 cycles, div_err = 1 and sticky, FSM returns to IDLE. A coincident div_done on the last BUSY cycle -> div_err stays 0.
- Reset mid-BUSY: assert rst asynchronously -> div_busy = 0, div_err = 0, stall_e = 0 immediately with div_e = 0.
- Div plus branch: div in EX with branchstall = 1 -> flush_e = 0, stall_d = 1.
